// File: rtl/exe_stage.sv
// Execute stage: Val2 shifter, ALU with NZCV flags, branch target adder,
// CPSR status register and the EXE->MEM pipeline register.
module exe_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              writeBackEn,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [3:0]        executeCommand,
  input  logic              s,
  input  logic              branch,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] reg1Val,
  input  logic [DATA_W-1:0] reg2Val,
  input  logic              immediate,
  input  logic [11:0]       shiftOperand,
  input  logic [23:0]       signedImmediate,
  input  logic [3:0]        destination,
  output logic              branchTaken,
  output logic [DATA_W-1:0] branchAddress,
  output logic [3:0]        status,
  output logic              wbEnOut,
  output logic              memReadOut,
  output logic              memWriteOut,
  output logic [DATA_W-1:0] aluResult,
  output logic [DATA_W-1:0] storeVal,
  output logic [3:0]        destOut
);

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    ror32 = (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [32:0] sum;
  logic        add_op, sub_op;
  logic        n_flag, z_flag, c_flag, v_flag;
  logic        c_in;

  logic [3:0]  status_q, status_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_val_q, store_val_d;
  logic [3:0]  dest_q, dest_d;

  assign c_in = status_q[1];

  // Memory offset wins over immediate so loads/stores always form reg1Val + offset.
  always_comb begin
    val2 = reg2Val;
    if (memRead || memWrite) begin
      val2 = {20'b0, shiftOperand};
    end else if (immediate) begin
      val2 = ror32({24'b0, shiftOperand[7:0]}, {shiftOperand[11:8], 1'b0});
    end else begin
      case (shiftOperand[6:5])
        2'b00:   val2 = reg2Val << shiftOperand[11:7];
        2'b01:   val2 = reg2Val >> shiftOperand[11:7];
        2'b10:   val2 = $signed(reg2Val) >>> shiftOperand[11:7];
        default: val2 = ror32(reg2Val, shiftOperand[11:7]);
      endcase
    end
  end

  // Subtraction is a + ~b + 1 so the carry out directly means "no borrow".
  always_comb begin
    sum     = 33'd0;
    add_op  = 1'b0;
    sub_op  = 1'b0;
    alu_res = 32'd0;
    case (executeCommand)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010: begin
        add_op = 1'b1;
        sum    = {1'b0, reg1Val} + {1'b0, val2};
      end
      4'b0011: begin
        add_op = 1'b1;
        sum    = {1'b0, reg1Val} + {1'b0, val2} + {32'd0, c_in};
      end
      4'b0100: begin
        sub_op = 1'b1;
        sum    = {1'b0, reg1Val} + {1'b0, ~val2} + 33'd1;
      end
      4'b0101: begin
        sub_op = 1'b1;
        sum    = {1'b0, reg1Val} + {1'b0, ~val2} + {32'd0, c_in};
      end
      4'b0110: alu_res = reg1Val & val2;
      4'b0111: alu_res = reg1Val | val2;
      4'b1000: alu_res = reg1Val ^ val2;
      default: alu_res = 32'd0;
    endcase
    if (add_op || sub_op) alu_res = sum[31:0];
  end

  always_comb begin
    n_flag = alu_res[31];
    z_flag = (alu_res == 32'd0);
    c_flag = status_q[1];
    v_flag = status_q[0];
    if (add_op) begin
      c_flag = sum[32];
      v_flag = (reg1Val[31] == val2[31]) && (alu_res[31] != reg1Val[31]);
    end else if (sub_op) begin
      c_flag = sum[32];
      v_flag = (reg1Val[31] != val2[31]) && (alu_res[31] != reg1Val[31]);
    end
  end

  always_comb begin
    status_d     = status_q;
    wb_en_d      = wb_en_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    alu_result_d = alu_result_q;
    store_val_d  = store_val_q;
    dest_d       = dest_q;
    if (!freeze) begin
      if (s) status_d = {n_flag, z_flag, c_flag, v_flag};
      wb_en_d      = writeBackEn;
      mem_read_d   = memRead;
      mem_write_d  = memWrite;
      alu_result_d = alu_res;
      store_val_d  = reg2Val;
      dest_d       = destination;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q     <= 4'd0;
      wb_en_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_result_q <= 32'd0;
      store_val_q  <= 32'd0;
      dest_q       <= 4'd0;
    end else begin
      status_q     <= status_d;
      wb_en_q      <= wb_en_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_result_q <= alu_result_d;
      store_val_q  <= store_val_d;
      dest_q       <= dest_d;
    end
  end

  assign branchTaken   = branch;
  assign branchAddress = PC + {{6{signedImmediate[23]}}, signedImmediate, 2'b00};
  assign status        = status_q;
  assign wbEnOut       = wb_en_q;
  assign memReadOut    = mem_read_q;
  assign memWriteOut   = mem_write_q;
  assign aluResult     = alu_result_q;
  assign storeVal      = store_val_q;
  assign destOut       = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, flags, shifter modes, freeze,
// same-cycle branch target, async reset and load address formation.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        writeBackEn, memRead, memWrite;
  logic [3:0]  executeCommand;
  logic        s, branch;
  logic [31:0] PC, reg1Val, reg2Val;
  logic        immediate;
  logic [11:0] shiftOperand;
  logic [23:0] signedImmediate;
  logic [3:0]  destination;
  logic        branchTaken;
  logic [31:0] branchAddress;
  logic [3:0]  status;
  logic        wbEnOut, memReadOut, memWriteOut;
  logic [31:0] aluResult, storeVal;
  logic [3:0]  destOut;

  int n_cmp = 0;
  int n_bad = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .writeBackEn(writeBackEn),
    .memRead(memRead), .memWrite(memWrite), .executeCommand(executeCommand),
    .s(s), .branch(branch), .PC(PC), .reg1Val(reg1Val), .reg2Val(reg2Val),
    .immediate(immediate), .shiftOperand(shiftOperand),
    .signedImmediate(signedImmediate), .destination(destination),
    .branchTaken(branchTaken), .branchAddress(branchAddress), .status(status),
    .wbEnOut(wbEnOut), .memReadOut(memReadOut), .memWriteOut(memWriteOut),
    .aluResult(aluResult), .storeVal(storeVal), .destOut(destOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] op, input logic sv, input logic [31:0] a,
                     input logic [31:0] b, input logic imm, input logic [11:0] shop);
    executeCommand = op;
    s              = sv;
    reg1Val        = a;
    reg2Val        = b;
    immediate      = imm;
    shiftOperand   = shop;
    step();
  endtask

  task automatic check_res(input string tag, input logic [31:0] res, input logic [3:0] st);
    check({tag, "_res"}, aluResult, res);
    check({tag, "_nzcv"}, {28'd0, status}, {28'd0, st});
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; writeBackEn = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    executeCommand = 4'd0; s = 1'b0; branch = 1'b0; PC = 32'd0; reg1Val = 32'd0;
    reg2Val = 32'd0; immediate = 1'b0; shiftOperand = 12'd0; signedImmediate = 24'd0;
    destination = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu", aluResult, 32'd0);
    check("rst_status", {28'd0, status}, 32'd0);
    check("rst_ctrl", {29'd0, wbEnOut, memReadOut, memWriteOut}, 32'd0);
    rst = 1'b0;

    writeBackEn = 1'b1; destination = 4'd7;
    alu(4'b0010, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 12'h000);
    check_res("add_ovf", 32'h80000000, 4'b1001);
    check("add_dest", {28'd0, destOut}, 32'd7);
    check("add_wb", {31'd0, wbEnOut}, 32'd1);
    check("add_store", storeVal, 32'd1);
    alu(4'b0100, 1'b1, 32'd5, 32'd5, 1'b0, 12'h000);
    check_res("cmp_eq", 32'd0, 4'b0110);
    alu(4'b0011, 1'b1, 32'd1, 32'd1, 1'b0, 12'h000);
    check_res("adc_c1", 32'd3, 4'b0000);
    alu(4'b0101, 1'b1, 32'd5, 32'd3, 1'b0, 12'h000);
    check_res("sbc_c0", 32'd1, 4'b0010);
    alu(4'b0001, 1'b0, 32'd0, 32'd0, 1'b1, 12'h4FF);
    check_res("mov_rotimm", 32'hFF000000, 4'b0010);
    alu(4'b0001, 1'b1, 32'd0, 32'h80000000, 1'b0, 12'h240);
    check_res("mov_asr4", 32'hF8000000, 4'b1010);
    alu(4'b0001, 1'b0, 32'd0, 32'h80000000, 1'b0, 12'h220);
    check("mov_lsr4", aluResult, 32'h08000000);
    alu(4'b0001, 1'b0, 32'd0, 32'h0000000F, 1'b0, 12'h260);
    check("mov_ror4", aluResult, 32'hF0000000);
    alu(4'b0001, 1'b0, 32'd0, 32'h00000001, 1'b0, 12'h200);
    check("mov_lsl4", aluResult, 32'h00000010);
    alu(4'b0001, 1'b0, 32'd0, 32'h12345678, 1'b0, 12'h060);
    check("mov_shamt0", aluResult, 32'h12345678);
    alu(4'b0001, 1'b0, 32'd0, 32'd0, 1'b1, 12'h0AB);
    check("mov_rot0", aluResult, 32'h000000AB);
    alu(4'b1001, 1'b1, 32'd0, 32'd0, 1'b0, 12'h000);
    check_res("mvn_zero", 32'hFFFFFFFF, 4'b1010);
    alu(4'b0110, 1'b1, 32'h0000F0F0, 32'h0000FF00, 1'b0, 12'h000);
    check_res("and", 32'h0000F000, 4'b0010);
    alu(4'b0111, 1'b0, 32'h000000F0, 32'h0000000F, 1'b0, 12'h000);
    check("orr", aluResult, 32'h000000FF);
    alu(4'b1000, 1'b1, 32'h000000FF, 32'h000000FF, 1'b0, 12'h000);
    check_res("eor_zero", 32'd0, 4'b0110);
    alu(4'b1111, 1'b1, 32'd1, 32'd1, 1'b0, 12'h000);
    check_res("bad_op", 32'd0, 4'b0110);
    alu(4'b0100, 1'b1, 32'h80000000, 32'd1, 1'b0, 12'h000);
    check_res("sub_ovf", 32'h7FFFFFFF, 4'b0011);

    // Freeze holds both registers; branch outputs stay live.
    freeze = 1'b1; writeBackEn = 1'b0; destination = 4'd2;
    for (int i = 0; i < 3; i++) begin
      alu(4'b0010, 1'b1, 32'd1, 32'd2, 1'b0, 12'h000);
      check("frz_res", aluResult, 32'h7FFFFFFF);
      check("frz_nzcv", {28'd0, status}, 32'h3);
      check("frz_dest", {28'd0, destOut}, 32'd7);
    end
    branch = 1'b1; PC = 32'h100; signedImmediate = 24'hFFFFFE;
    #1;
    check("br_taken", {31'd0, branchTaken}, 32'd1);
    check("br_addr", branchAddress, 32'h000000F8);
    branch = 1'b0; signedImmediate = 24'h000010;
    #1;
    check("br_fwd", branchAddress, 32'h00000140);
    check("br_not", {31'd0, branchTaken}, 32'd0);
    freeze = 1'b0;
    step();
    check_res("unfrz", 32'd3, 4'b0000);
    check("unfrz_wb", {31'd0, wbEnOut}, 32'd0);

    // Reset asserted between edges must clear outputs before the next edge.
    writeBackEn = 1'b1; destination = 4'd9;
    alu(4'b0100, 1'b1, 32'd1, 32'd2, 1'b0, 12'h000);
    check_res("pre_rst", 32'hFFFFFFFF, 4'b1000);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_alu", aluResult, 32'd0);
    check("mid_rst_status", {28'd0, status}, 32'd0);
    check("mid_rst_dest", {28'd0, destOut}, 32'd0);
    check("mid_rst_wb", {31'd0, wbEnOut}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    memRead = 1'b1; destination = 4'd3;
    alu(4'b0010, 1'b0, 32'h00001000, 32'hDEADBEEF, 1'b1, 12'h123);
    check("ldr_addr", aluResult, 32'h00001123);
    check("ldr_ctrl", {29'd0, wbEnOut, memReadOut, memWriteOut}, 32'b110);
    memRead = 1'b0; memWrite = 1'b1; writeBackEn = 1'b0;
    alu(4'b0010, 1'b0, 32'h00002000, 32'hCAFEF00D, 1'b0, 12'hFFF);
    check("str_addr", aluResult, 32'h00002FFF);
    check("str_data", storeVal, 32'hCAFEF00D);
    check("str_ctrl", {29'd0, wbEnOut, memReadOut, memWriteOut}, 32'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
